store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending-store entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port st_valid  input  1  store request from the memory stage.
REQ-005 SHALL have ports sb, sh  input  1 each  store-size decode: 00 = sw, 01 = sh, 10 = sb, 11 treated as sw.
REQ-006 SHALL have port st_addr  input  32  byte address of the store.
REQ-007 SHALL have port st_data  input  32  store-modifier output; payload in low lanes, upper bits zero.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port misalign  output  1  one-cycle pulse: rejected misaligned store.
REQ-010 SHALL have port ld_addr  input  32  address of the load in the memory stage.
REQ-011 SHALL have port ld_conflict  output  1  a pending entry matches the load word address.
REQ-012 SHALL have port mem_valid  output  1  write request to data memory.
REQ-013 SHALL have port mem_ready  input  1  data memory accepts the write.
REQ-014 SHALL have ports mem_addr / mem_wdata / mem_wstrb  output  32/32/4  word-aligned address, lane-aligned data, byte enables.
REQ-015 SHALL have port empty  output  1  no pending entries; used by fence.

Function
REQ-016 SHALL accept a store on a rising edge when st_valid && st_ready && address is aligned.
REQ-017 SHALL treat alignment as: sw needs addr[1:0]=00; sh needs addr[0]=0; sb always aligned.
REQ-018 SHALL, on st_valid with a misaligned address, drop the store and assert misalign for exactly the next cycle.
REQ-019 SHALL shift st_data left by 8*addr[1:0] into lane position; sb wstrb = 0001<<addr[1:0]; sh wstrb = 0011<<addr[1:0]; sw wstrb = 1111.
REQ-020 SHALL store entry address as {st_addr[31:2],2'b00}.
REQ-021 SHALL be FIFO-ordered; head entry drives mem_addr, mem_wdata and mem_wstrb.
REQ-022 SHALL assert mem_valid iff count>0; outputs SHALL hold stable while mem_valid && !mem_ready.
REQ-023 SHALL pop the head on a rising edge with mem_valid && mem_ready.
REQ-024 SHALL make an accepted store visible on the memory interface one cycle after acceptance (minimum latency 1, no bypass).
REQ-025 SHALL drive st_ready = (count<DEPTH), from registered count only; when full, a same-cycle pop does not raise st_ready until the next cycle.
REQ-026 SHALL, on push and pop in the same cycle, leave count unchanged and advance both pointers.
REQ-027 SHALL wrap read and write pointers modulo DEPTH; count width = log2(DEPTH)+1.
REQ-028 SHALL drive ld_conflict combinationally: any valid entry whose word address equals ld_addr[31:2]; the entry being popped this cycle still counts.
REQ-029 SHALL drive empty = (count==0).

Reset
REQ-030 SHALL, on rst, clear count and both pointers; mem_valid=0, st_ready=1, misalign=0, empty=1, ld_conflict=0.
REQ-031 SHALL discard pending entries on rst mid-operation; a mem handshake in the rst cycle is ignored.
REQ-032 SHALL leave entry data arrays unreset; their values are don't-care while invalid.

Structure
REQ-033 SHALL take size-encoding constants (SZ_W/SZ_H/SZ_B) and wstrb patterns from the shared core constants package, also used by store_modifier and the load path.
REQ-034 SHALL use one combinational sub-module, store_lane_align (size, addr[1:0], data -> wdata, wstrb, misaligned); FIFO control is inline.

Verification
REQ-035 SHALL test sb: addr 0x1003, st_data 0x000000AB -> next cycle mem_addr 0x1000, wdata 0xAB000000, wstrb 1000.
REQ-036 SHALL test sh: addr 0x2002, data 0x0000BEEF -> wdata 0xBEEF0000, wstrb 1100; sh at 0x2001 -> misalign pulse, no entry.
REQ-037 SHALL test fill: 4 stores with mem_ready=0 -> st_ready=0 after the 4th; one pop -> st_ready=1 the following cycle; order preserved.
REQ-038 SHALL test simultaneous push+pop at count=2 -> count stays 2; pointer wrap over 10+ stores shows no loss or reorder.
REQ-039 SHALL test ld_conflict: pending sw at 0x3000; ld_addr 0x3002 -> 1, 0x3004 -> 0; after drain -> 0.
REQ-040 SHALL test rst with 3 pending entries and mem_valid high -> next cycle mem_valid=0, empty=1, st_ready=1.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Core constants shared by the store path: store-size encodings and byte-enable patterns.
// The decode helper maps the {sb, sh} pair onto a size code.
package store_buffer_pkg;

    typedef enum logic [1:0] {
        SZ_W = 2'b00,
        SZ_H = 2'b01,
        SZ_B = 2'b10
    } st_size_e;

    localparam logic [3:0] WSTRB_B = 4'b0001;
    localparam logic [3:0] WSTRB_H = 4'b0011;
    localparam logic [3:0] WSTRB_W = 4'b1111;

    // Both decode bits set is not a legal encoding and falls back to a word store.
    function automatic st_size_e decode_size(input logic sb, input logic sh);
        st_size_e size;
        if (sb && !sh) begin
            size = SZ_B;
        end else if (!sb && sh) begin
            size = SZ_H;
        end else begin
            size = SZ_W;
        end
        return size;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Moves store payload into its byte lanes, builds the byte enables and flags
// addresses that do not meet the natural alignment of the store size.
module store_lane_align
    import store_buffer_pkg::*;
(
    input  st_size_e    size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    always_comb begin
        wdata      = data << {offset, 3'b000};
        wstrb      = WSTRB_W;
        misaligned = 1'b0;
        case (size)
            SZ_B: begin
                wstrb = WSTRB_B << offset;
            end
            SZ_H: begin
                wstrb      = WSTRB_H << offset;
                misaligned = offset[0];
            end
            default: begin
                wstrb      = WSTRB_W;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// FIFO of pending stores between the memory stage and data memory; the head entry
// is presented to memory until accepted, and loads are checked against every pending word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic        sb,
    input  logic        sh,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        misalign,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             misalign_q;

    logic [29:0] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [3:0]  strb_mem [DEPTH];

    st_size_e    size;
    logic [31:0] lane_data;
    logic [3:0]  lane_strb;
    logic        lane_misaligned;
    logic        push;
    logic        pop;
    logic [PTR_W-1:0] slot_offset;

    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    assign size = decode_size(sb, sh);

    store_lane_align u_align (
        .size       (size),
        .offset     (st_addr[1:0]),
        .data       (st_data),
        .wdata      (lane_data),
        .wstrb      (lane_strb),
        .misaligned (lane_misaligned)
    );

    // st_ready looks only at the registered count, so a pop never frees a slot in the same cycle.
    assign st_ready  = (count < CNT_W'(DEPTH));
    assign push      = st_valid && st_ready && !lane_misaligned;
    assign mem_valid = (count != '0);
    assign pop       = mem_valid && mem_ready;
    assign empty     = (count == '0);
    assign misalign  = misalign_q;

    assign mem_addr  = {addr_mem[rd_ptr], 2'b00};
    assign mem_wdata = data_mem[rd_ptr];
    assign mem_wstrb = strb_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            misalign_q <= st_valid && lane_misaligned;
        end
    end

    // Entry storage carries no reset; only slots inside the count window are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= st_addr[31:2];
            data_mem[wr_ptr] <= lane_data;
            strb_mem[wr_ptr] <= lane_strb;
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        ld_conflict = 1'b0;
        slot_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(slot_offset) < count) && (addr_mem[i] == ld_addr[31:2])) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus randomized traffic against a
// queue-based model of the pending-store FIFO.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        sb;
    logic        sh;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        misalign;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        empty;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t mq[$];
    logic m_mis = 1'b0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .sb          (sb),
        .sh          (sh),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .misalign    (misalign),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .empty       (empty)
    );

    function automatic bit m_aligned(input logic b, input logic h, input logic [31:0] a);
        if (b && !h) return 1'b1;
        if (!b && h) return (a[0] == 1'b0);
        return (a[1:0] == 2'b00);
    endfunction

    function automatic ent_t m_entry(input logic b, input logic h, input logic [31:0] a,
                                     input logic [31:0] d);
        ent_t e;
        int   sh_bytes;
        sh_bytes = int'(a[1:0]);
        e.addr = a & 32'hFFFF_FFFC;
        e.data = d << (8 * sh_bytes);
        if (b && !h)      e.strb = 4'b0001 << sh_bytes;
        else if (!b && h) e.strb = 4'b0011 << sh_bytes;
        else              e.strb = 4'b1111;
        return e;
    endfunction

    function automatic bit m_conflict(input logic [31:0] la);
        foreach (mq[i]) begin
            if (mq[i].addr[31:2] == la[31:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: the model samples the same inputs the DUT sees at the rising edge.
    task automatic tick();
        bit   acc;
        bit   pp;
        bit   mis_n;
        ent_t e;
        acc   = st_valid && (mq.size() < DEPTH) && m_aligned(sb, sh, st_addr);
        pp    = (mq.size() > 0) && mem_ready;
        mis_n = st_valid && !m_aligned(sb, sh, st_addr);
        e     = m_entry(sb, sh, st_addr, st_data);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_mis = 1'b0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            m_mis = mis_n;
        end
        #1;
    endtask

    task automatic idle_inputs();
        st_valid  = 1'b0;
        sb        = 1'b0;
        sh        = 1'b0;
        st_addr   = 32'h0;
        st_data   = 32'h0;
        mem_ready = 1'b0;
        ld_addr   = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        compared++;
        if (mem_valid !== 1'b0) begin mismatched++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        compared++;
        if (st_ready !== 1'b1) begin mismatched++; $display("FAIL reset_st_ready got %b want 1", st_ready); end
        compared++;
        if (misalign !== 1'b0) begin mismatched++; $display("FAIL reset_misalign got %b want 0", misalign); end
        compared++;
        if (empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty got %b want 1", empty); end
        compared++;
        if (ld_conflict !== 1'b0) begin mismatched++; $display("FAIL reset_ld_conflict got %b want 0", ld_conflict); end
    endtask

    task automatic test_sb();
        st_valid = 1'b1; sb = 1'b1; sh = 1'b0;
        st_addr = 32'h0000_1003; st_data = 32'h0000_00AB; mem_ready = 1'b0;
        #1;
        compared++;
        if (mem_valid !== 1'b0) begin mismatched++; $display("FAIL sb_no_bypass mem_valid got %b want 0", mem_valid); end
        tick();
        st_valid = 1'b0; sb = 1'b0;
        #1;
        compared++;
        if (mem_valid !== 1'b1) begin mismatched++; $display("FAIL sb_mem_valid got %b want 1", mem_valid); end
        compared++;
        if (mem_addr !== 32'h0000_1000) begin mismatched++; $display("FAIL sb_addr got %h want 00001000", mem_addr); end
        compared++;
        if (mem_wdata !== 32'hAB00_0000) begin mismatched++; $display("FAIL sb_wdata got %h want ab000000", mem_wdata); end
        compared++;
        if (mem_wstrb !== 4'b1000) begin mismatched++; $display("FAIL sb_wstrb got %b want 1000", mem_wstrb); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        compared++;
        if (empty !== 1'b1) begin mismatched++; $display("FAIL sb_drained empty got %b want 1", empty); end
    endtask

    task automatic test_sh();
        st_valid = 1'b1; sb = 1'b0; sh = 1'b1;
        st_addr = 32'h0000_2002; st_data = 32'h0000_BEEF; mem_ready = 1'b0;
        tick();
        st_valid = 1'b0;
        #1;
        compared++;
        if (mem_wdata !== 32'hBEEF_0000) begin mismatched++; $display("FAIL sh_wdata got %h want beef0000", mem_wdata); end
        compared++;
        if (mem_wstrb !== 4'b1100) begin mismatched++; $display("FAIL sh_wstrb got %b want 1100", mem_wstrb); end
        compared++;
        if (mem_addr !== 32'h0000_2000) begin mismatched++; $display("FAIL sh_addr got %h want 00002000", mem_addr); end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h0000_2001;
        tick();
        st_valid = 1'b0; sh = 1'b0;
        #1;
        compared++;
        if (misalign !== 1'b1) begin mismatched++; $display("FAIL sh_misalign_pulse got %b want 1", misalign); end
        compared++;
        if (empty !== 1'b1) begin mismatched++; $display("FAIL sh_misalign_no_entry empty got %b want 1", empty); end
        tick();
        compared++;
        if (misalign !== 1'b0) begin mismatched++; $display("FAIL sh_misalign_one_cycle got %b want 0", misalign); end
    endtask

    task automatic test_fill();
        mem_ready = 1'b0; sb = 1'b0; sh = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h0000_0100 * (i + 1);
            st_data  = $urandom;
            tick();
        end
        st_valid = 1'b0;
        #1;
        compared++;
        if (st_ready !== 1'b0) begin mismatched++; $display("FAIL fill_full st_ready got %b want 0", st_ready); end
        // Attempted push while full, with a pop in the same cycle: must be refused.
        st_valid = 1'b1; st_addr = 32'h0000_0900; st_data = 32'h1234_5678; mem_ready = 1'b1;
        #1;
        compared++;
        if (st_ready !== 1'b0) begin mismatched++; $display("FAIL fill_pop_cycle st_ready got %b want 0", st_ready); end
        tick();
        st_valid = 1'b0; mem_ready = 1'b0;
        #1;
        compared++;
        if (st_ready !== 1'b1) begin mismatched++; $display("FAIL fill_after_pop st_ready got %b want 1", st_ready); end
        mem_ready = 1'b1;
        for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) begin
            compared++;
            if (mem_valid !== 1'b1 || mem_addr !== mq[0].addr || mem_wdata !== mq[0].data)
            begin
                mismatched++;
                $display("FAIL fill_order got v=%b a=%h d=%h want v=1 a=%h d=%h",
                         mem_valid, mem_addr, mem_wdata, mq[0].addr, mq[0].data);
            end
            tick();
        end
        mem_ready = 1'b0;
        #1;
        compared++;
        if (empty !== 1'b1 || mq.size() != 0) begin mismatched++; $display("FAIL fill_drain empty got %b want 1", empty); end
    endtask

    task automatic test_back_to_back();
        int pops;
        sb = 1'b0; sh = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            st_valid = 1'b1; st_addr = 32'h0000_5000 + 4 * i; st_data = 32'hA000_0000 + i;
            tick();
        end
        st_valid = 1'b1; st_addr = 32'h0000_5008; st_data = 32'hA000_0002; mem_ready = 1'b1;
        tick();
        st_valid = 1'b0; mem_ready = 1'b0;
        #1;
        compared++;
        if (mem_addr !== 32'h0000_5004 || mem_wdata !== 32'hA000_0001)
        begin
            mismatched++;
            $display("FAIL b2b_head got a=%h d=%h want a=00005004 d=a0000001", mem_addr, mem_wdata);
        end
        pops = 0;
        mem_ready = 1'b1;
        for (int k = 0; k < 8 && mem_valid === 1'b1; k++) begin
            pops++;
            tick();
        end
        mem_ready = 1'b0;
        compared++;
        if (pops != 2) begin mismatched++; $display("FAIL b2b_count got %0d pops want 2", pops); end
        // Streaming through the FIFO wraps the pointers several times.
        for (int i = 0; i < 14; i++) begin
            st_valid = 1'b1; st_addr = 32'h0000_6000 + 4 * i; st_data = $urandom;
            mem_ready = (i > 0);
            #1;
            if (mq.size() > 0) begin
                compared++;
                if (mem_valid !== 1'b1 || mem_addr !== mq[0].addr || mem_wdata !== mq[0].data)
                begin
                    mismatched++;
                    $display("FAIL wrap_order got a=%h d=%h want a=%h d=%h",
                             mem_addr, mem_wdata, mq[0].addr, mq[0].data);
                end
            end
            tick();
        end
        st_valid = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            compared++;
            if (mem_addr !== mq[0].addr || mem_wdata !== mq[0].data)
            begin
                mismatched++;
                $display("FAIL wrap_drain got a=%h d=%h want a=%h d=%h",
                         mem_addr, mem_wdata, mq[0].addr, mq[0].data);
            end
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_ld_conflict();
        sb = 1'b0; sh = 1'b0; mem_ready = 1'b0;
        st_valid = 1'b1; st_addr = 32'h0000_3000; st_data = $urandom;
        tick();
        st_valid = 1'b0;
        ld_addr = 32'h0000_3002;
        #1;
        compared++;
        if (ld_conflict !== 1'b1) begin mismatched++; $display("FAIL ldc_same_word got %b want 1", ld_conflict); end
        ld_addr = 32'h0000_3004;
        #1;
        compared++;
        if (ld_conflict !== 1'b0) begin mismatched++; $display("FAIL ldc_next_word got %b want 0", ld_conflict); end
        ld_addr = 32'h0000_3000; mem_ready = 1'b1;
        #1;
        compared++;
        if (ld_conflict !== 1'b1) begin mismatched++; $display("FAIL ldc_popping got %b want 1", ld_conflict); end
        tick();
        mem_ready = 1'b0;
        #1;
        compared++;
        if (ld_conflict !== 1'b0) begin mismatched++; $display("FAIL ldc_drained got %b want 0", ld_conflict); end
        ld_addr = 32'h0;
    endtask

    task automatic test_rst_mid();
        sb = 1'b0; sh = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1; st_addr = 32'h0000_7000 + 4 * i; st_data = $urandom;
            tick();
        end
        st_valid = 1'b0;
        #1;
        compared++;
        if (mem_valid !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre mem_valid got %b want 1", mem_valid); end
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        compared++;
        if (mem_valid !== 1'b0) begin mismatched++; $display("FAIL rstmid_mem_valid got %b want 0", mem_valid); end
        compared++;
        if (empty !== 1'b1) begin mismatched++; $display("FAIL rstmid_empty got %b want 1", empty); end
        compared++;
        if (st_ready !== 1'b1) begin mismatched++; $display("FAIL rstmid_st_ready got %b want 1", st_ready); end
    endtask

    task automatic test_random();
        logic [31:0] la;
        for (int c = 0; c < 400; c++) begin
            st_valid  = ($urandom_range(0, 2) != 0);
            sb        = $urandom_range(0, 1);
            sh        = $urandom_range(0, 1);
            st_addr   = 32'h0000_8000 + 32'($urandom_range(0, 31));
            st_data   = $urandom;
            if (sb && !sh)      st_data = st_data & 32'h0000_00FF;
            else if (!sb && sh) st_data = st_data & 32'h0000_FFFF;
            mem_ready = ($urandom_range(0, 2) == 0);
            la        = 32'h0000_8000 + 32'($urandom_range(0, 31));
            ld_addr   = la;
            #1;
            compared++;
            if (mem_valid !== (mq.size() > 0) || st_ready !== (mq.size() < DEPTH) ||
                empty !== (mq.size() == 0) || misalign !== m_mis)
            begin
                mismatched++;
                $display("FAIL rand_ctrl cyc %0d got v=%b r=%b e=%b m=%b want size=%0d m=%b",
                         c, mem_valid, st_ready, empty, misalign, mq.size(), m_mis);
            end
            compared++;
            if (ld_conflict !== m_conflict(la))
            begin
                mismatched++;
                $display("FAIL rand_ldc cyc %0d got %b want %b", c, ld_conflict, m_conflict(la));
            end
            if (mq.size() > 0) begin
                compared++;
                if (mem_addr !== mq[0].addr || mem_wdata !== mq[0].data || mem_wstrb !== mq[0].strb)
                begin
                    mismatched++;
                    $display("FAIL rand_head cyc %0d got a=%h d=%h s=%b want a=%h d=%h s=%b",
                             c, mem_addr, mem_wdata, mem_wstrb, mq[0].addr, mq[0].data, mq[0].strb);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sb();
        test_sh();
        test_fill();
        test_back_to_back();
        test_ld_conflict();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
